// File: rtl/jk_drv_pkg.sv
// Shared types and constants for the JK excitation driver.
package jk_drv_pkg;

  typedef enum logic {
    IDLE,
    DRIVE
  } drv_state_e;

  localparam logic [1:0] ENC_TOGGLE = 2'd0;
  localparam logic [1:0] ENC_FORCE  = 2'd1;
  localparam logic [1:0] ENC_MINSR  = 2'd2;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_excite_enc.sv
// Bitwise JK excitation encoder: picks per-bit J/K codes that move cur to tgt.
module jk_excite_enc
  import jk_drv_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] tgt,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  logic [1:0] code;

  always_comb begin
    j = '0;
    k = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      code = JK_HOLD;
      unique case (mode)
        ENC_TOGGLE: code = (cur[i] != tgt[i]) ? JK_TGL : JK_HOLD;
        ENC_FORCE:  code = tgt[i] ? JK_SET : JK_RST;
        ENC_MINSR:  code = (cur[i] == tgt[i]) ? JK_HOLD : (tgt[i] ? JK_SET : JK_RST);
        default:    code = JK_HOLD;
      endcase
      j[i] = code[1];
      k[i] = code[0];
    end
  end

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives an external negedge JK bank to a requested word, verifies via q_fb,
// retries on mismatch and reports done / err.
module jk_excitation_driver
  import jk_drv_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ENC_MODE  = 2,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] q_fb,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             fault
);

  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [1:0]  MODE = 2'(ENC_MODE);

  drv_state_e       state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             fault_q, fault_d;

  logic [WIDTH-1:0] enc_tgt, enc_j, enc_k;

  // In IDLE the encoder looks at the incoming word; in DRIVE at the captured one.
  assign enc_tgt = (state_q == IDLE) ? tgt_data : tgt_q;

  jk_excite_enc #(.WIDTH(WIDTH)) u_enc (
    .cur  (q_fb),
    .tgt  (enc_tgt),
    .mode (MODE),
    .j    (enc_j),
    .k    (enc_k)
  );

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    retry_d = retry_q;
    j_d     = j_q;
    k_d     = k_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    fault_d = fault_q;
    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        j_d     = '0;
        k_d     = '0;
        if (tgt_valid && ready_q) begin
          state_d = DRIVE;
          tgt_d   = tgt_data;
          retry_d = '0;
          j_d     = enc_j;
          k_d     = enc_k;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          fault_d = 1'b0;
        end
      end
      DRIVE: begin
        if (q_fb == tgt_q) begin
          state_d = IDLE;
          j_d     = '0;
          k_d     = '0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (retry_q != RW'(MAX_RETRY)) begin
          retry_d = retry_q + RW'(1);
          j_d     = enc_j;
          k_d     = enc_k;
        end else begin
          state_d = IDLE;
          j_d     = '0;
          k_d     = '0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          fault_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      retry_q <= '0;
      j_q     <= '0;
      k_q     <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      retry_q <= retry_d;
      j_q     <= j_d;
      k_q     <= k_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      fault_q <= fault_d;
    end
  end

  assign tgt_ready = ready_q;
  assign j         = j_q;
  assign k         = k_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: one instance per encoding mode, each driving
// its own modelled negedge JK bank.
module tb_jk_excitation_driver;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [7:0]      tgt_data = '0;
  logic [2:0]      vld = '0;
  logic [2:0]      rdy, bsy, dn, er, flt;
  logic [2:0][7:0] jv, kv, bq, fb;
  logic            stuck = 1'b0;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  always @(negedge clk or negedge rst) begin
    if (!rst) bq <= '0;
    else for (int i = 0; i < 3; i++) bq[i] <= (jv[i] & ~bq[i]) | (~kv[i] & bq[i]);
  end

  assign fb[0] = bq[0] & ~{7'b0, stuck};
  assign fb[1] = bq[1];
  assign fb[2] = bq[2];

  jk_excitation_driver #(.WIDTH(8), .ENC_MODE(2), .MAX_RETRY(2)) u_minsr (
    .clk(clk), .rst(rst), .tgt_data(tgt_data), .tgt_valid(vld[0]), .tgt_ready(rdy[0]),
    .j(jv[0]), .k(kv[0]), .q_fb(fb[0]), .busy(bsy[0]), .done(dn[0]), .err(er[0]), .fault(flt[0]));

  jk_excitation_driver #(.WIDTH(8), .ENC_MODE(0), .MAX_RETRY(2)) u_toggle (
    .clk(clk), .rst(rst), .tgt_data(tgt_data), .tgt_valid(vld[1]), .tgt_ready(rdy[1]),
    .j(jv[1]), .k(kv[1]), .q_fb(fb[1]), .busy(bsy[1]), .done(dn[1]), .err(er[1]), .fault(flt[1]));

  jk_excitation_driver #(.WIDTH(8), .ENC_MODE(1), .MAX_RETRY(2)) u_force (
    .clk(clk), .rst(rst), .tgt_data(tgt_data), .tgt_valid(vld[2]), .tgt_ready(rdy[2]),
    .j(jv[2]), .k(kv[2]), .q_fb(fb[2]), .busy(bsy[2]), .done(dn[2]), .err(er[2]), .fault(flt[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int unsigned inst;
    logic [7:0]  tgt;
    logic [7:0]  exp_j;
    logic [7:0]  exp_k;
  } vec_t;

  vec_t vec[9];

  initial begin
    vec[0] = '{0, 8'hA5, 8'hA5, 8'h00};
    vec[1] = '{0, 8'h3C, 8'h18, 8'h81};
    vec[2] = '{0, 8'h3C, 8'h00, 8'h00};
    vec[3] = '{1, 8'hA5, 8'hA5, 8'hA5};
    vec[4] = '{1, 8'h5A, 8'hFF, 8'hFF};
    vec[5] = '{1, 8'h5A, 8'h00, 8'h00};
    vec[6] = '{2, 8'h0F, 8'h0F, 8'hF0};
    vec[7] = '{2, 8'h0F, 8'h0F, 8'hF0};
    vec[8] = '{2, 8'hF0, 8'hF0, 8'h0F};

    #12;
    chk("rst_ready", {29'b0, rdy}, 0);
    chk("rst_busy", {29'b0, bsy}, 0);
    chk("rst_jk", {jv[0], kv[0], jv[1], kv[1]}, 0);
    #2 rst = 1'b1;
    #1 chk("ready_before_edge", {29'b0, rdy}, 0);
    step();
    chk("ready_after_release", {29'b0, rdy}, 32'h7);

    for (int i = 0; i < 9; i++) begin
      tgt_data = vec[i].tgt;
      vld = 3'b001 << vec[i].inst;
      chk("vec_ready", 32'(rdy[vec[i].inst]), 1);
      step();
      vld = '0;
      chk("vec_j", 32'(jv[vec[i].inst]), 32'(vec[i].exp_j));
      chk("vec_k", 32'(kv[vec[i].inst]), 32'(vec[i].exp_k));
      chk("vec_busy", 32'(bsy[vec[i].inst]), 1);
      chk("vec_no_done_early", 32'(dn[vec[i].inst]), 0);
      step();
      chk("vec_done", 32'(dn[vec[i].inst]), 1);
      chk("vec_err", 32'(er[vec[i].inst]), 0);
      chk("vec_bank", 32'(bq[vec[i].inst]), 32'(vec[i].tgt));
    end

    // back-to-back with tgt_valid held high
    tgt_data = 8'h11; vld = 3'b001;
    step();
    chk("b2b_busy", 32'(bsy[0]), 1);
    chk("b2b_ready_low", 32'(rdy[0]), 0);
    chk("b2b_j", 32'(jv[0]), 32'h01);
    chk("b2b_k", 32'(kv[0]), 32'h2C);
    tgt_data = 8'h22;
    step();
    chk("b2b_done1", 32'(dn[0]), 1);
    chk("b2b_ready", 32'(rdy[0]), 1);
    chk("b2b_bank1", 32'(bq[0]), 32'h11);
    step();
    vld = '0;
    chk("b2b_busy2", 32'(bsy[0]), 1);
    chk("b2b_done_gap", 32'(dn[0]), 0);
    step();
    chk("b2b_done2", 32'(dn[0]), 1);
    chk("b2b_bank2", 32'(bq[0]), 32'h22);

    // stuck feedback bit exhausts retries
    stuck = 1'b1;
    tgt_data = 8'h01; vld = 3'b001;
    step();
    vld = '0;
    for (int c = 1; c <= 3; c++) begin
      chk("stuck_busy", 32'(bsy[0]), 1);
      chk("stuck_no_done", 32'(dn[0]), 0);
      chk("stuck_no_err", 32'(er[0]), 0);
      step();
    end
    chk("stuck_err", 32'(er[0]), 1);
    chk("stuck_fault", 32'(flt[0]), 1);
    chk("stuck_done", 32'(dn[0]), 0);
    chk("stuck_idle", 32'(bsy[0]), 0);
    chk("stuck_j", 32'(jv[0]), 0);
    step();
    chk("err_pulse", 32'(er[0]), 0);
    chk("fault_sticky", 32'(flt[0]), 1);
    stuck = 1'b0;
    tgt_data = 8'h02; vld = 3'b001;
    step();
    vld = '0;
    chk("fault_cleared", 32'(flt[0]), 0);
    step();
    chk("clean_done", 32'(dn[0]), 1);
    chk("clean_bank", 32'(bq[0]), 32'h02);

    // asynchronous reset in the middle of DRIVE
    tgt_data = 8'h3C; vld = 3'b010;
    step();
    vld = '0;
    chk("mid_busy", 32'(bsy[1]), 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_jk", {16'b0, jv[1], kv[1]}, 0);
    chk("mid_busy_drop", 32'(bsy[1]), 0);
    chk("mid_ready", 32'(rdy[1]), 0);
    step();
    chk("mid_no_done", 32'(dn[1]), 0);
    chk("mid_no_err", 32'(er[1]), 0);
    #2 rst = 1'b1;
    #1 chk("rel_ready_low", 32'(rdy[1]), 0);
    step();
    chk("rel_ready", 32'(rdy[1]), 1);
    chk("rel_no_done", 32'(dn[1]), 0);
    chk("rel_bank", 32'(bq[1]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
